// File: rtl/face_detect_mac_pipe.sv
// Pipelined signed/unsigned multiply-accumulate for the face-detect classifier path.
// NUM_STAGE-1 product registers feed a final stage that holds the running sum and sticky overflow.
module face_detect_mac_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic [1:0]            sign_mode,
    input  logic                  acc_en,
    input  logic                  acc_clr,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    if (NUM_STAGE < 1 || NUM_STAGE > 8 || dout_WIDTH < 2 || ID < 0) begin : g_param_err
        $error("face_detect_mac_pipe: illegal parameter set");
    end

    typedef struct packed {
        logic                  vld;
        logic                  acc;
        logic                  clr;
        logic [dout_WIDTH-1:0] prod;
    } beat_t;

    logic signed [din0_WIDTH:0] op0;
    logic signed [din1_WIDTH:0] op1;
    logic [dout_WIDTH-1:0]      op0_x;
    logic [dout_WIDTH-1:0]      op1_x;
    logic [dout_WIDTH-1:0]      prod_c;

    assign op0 = $signed({sign_mode[0] & din0[din0_WIDTH-1], din0});
    assign op1 = $signed({sign_mode[1] & din1[din1_WIDTH-1], din1});

    // Multiplying at dout width gives the low dout bits of the exact product,
    // which is also its sign extension when dout is wider than the exact result.
    if (din0_WIDTH + 1 <= dout_WIDTH) begin : g_op0_ext
        assign op0_x = dout_WIDTH'(op0);
    end else begin : g_op0_trunc
        assign op0_x = op0[dout_WIDTH-1:0];
    end

    if (din1_WIDTH + 1 <= dout_WIDTH) begin : g_op1_ext
        assign op1_x = dout_WIDTH'(op1);
    end else begin : g_op1_trunc
        assign op1_x = op1[dout_WIDTH-1:0];
    end

    assign prod_c = op0_x * op1_x;

    beat_t beat_in;
    beat_t beat_fin;

    assign beat_in = {in_valid, acc_en, acc_clr, prod_c};

    if (NUM_STAGE == 1) begin : g_direct
        assign beat_fin = beat_in;
    end else begin : g_pipe
        beat_t pipe_q [NUM_STAGE-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < NUM_STAGE - 1; i++) pipe_q[i] <= '0;
            end else if (ce) begin
                pipe_q[0] <= beat_in;
                for (int i = 1; i < NUM_STAGE - 1; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign beat_fin = pipe_q[NUM_STAGE-2];
    end

    logic [dout_WIDTH-1:0] sum;
    logic                  add_ovf;

    assign sum     = dout + beat_fin.prod;
    assign add_ovf = (dout[dout_WIDTH-1] == beat_fin.prod[dout_WIDTH-1]) &&
                     (sum[dout_WIDTH-1] != dout[dout_WIDTH-1]);

    // Bubbles leave dout/ovf untouched so the accumulation survives gaps in the stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            out_valid <= beat_fin.vld;
            if (beat_fin.vld) begin
                if (beat_fin.acc && !beat_fin.clr) begin
                    dout <= sum;
                    ovf  <= ovf | add_ovf;
                end else begin
                    dout <= beat_fin.prod;
                    ovf  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_face_detect_mac_pipe.sv
// Directed bench for face_detect_mac_pipe at default parameters (3 stages, 32x32 -> 64).
module tb_face_detect_mac_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic [31:0] din0;
    logic [31:0] din1;
    logic [1:0]  sign_mode;
    logic        acc_en;
    logic        acc_clr;
    logic        out_valid;
    logic [63:0] dout;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    face_detect_mac_pipe dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .in_valid (in_valid),
        .din0     (din0),
        .din1     (din1),
        .sign_mode(sign_mode),
        .acc_en   (acc_en),
        .acc_clr  (acc_clr),
        .out_valid(out_valid),
        .dout     (dout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic v, input logic [63:0] d, input logic o);
        check({name, "_valid"}, {63'd0, out_valid}, {63'd0, v});
        check({name, "_dout"}, dout, d);
        check({name, "_ovf"}, {63'd0, ovf}, {63'd0, o});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b,
                         input logic ae, input logic ac);
        in_valid  = 1'b1;
        sign_mode = sm;
        din0      = a;
        din1      = b;
        acc_en    = ae;
        acc_clr   = ac;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        din0     = '0;
        din1     = '0;
        acc_en   = 1'b0;
        acc_clr  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'b11, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[3] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001};
        vecs[4] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001};
        vecs[5] = '{2'b00, 32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000};
        vecs[6] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[7] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 64'hC000_0000_0000_0000};
        vecs[8] = '{2'b11, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
        vecs[9] = '{2'b11, 32'd0,         32'd12345,     64'h0000_0000_0000_0000};

        reset     = 1'b1;
        ce        = 1'b1;
        sign_mode = 2'b00;
        idle();
        step();
        chk_out("reset_state", 1'b0, 64'd0, 1'b0);
        reset = 1'b0;
        step();

        // Plain multiply: accept on one edge, silent on the next, result on the third.
        foreach (vecs[i]) begin
            drive(vecs[i].sm, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
            step();
            idle();
            step();
            check($sformatf("vec%0d_early", i), {63'd0, out_valid}, 64'd0);
            step();
            chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp, 1'b0);
            step();
            check($sformatf("vec%0d_drop", i), {63'd0, out_valid}, 64'd0);
        end

        // Back-to-back signed accumulation.
        drive(2'b11, 32'd2, 32'd3, 1'b1, 1'b1);
        step();
        drive(2'b11, 32'd4, 32'd5, 1'b1, 1'b0);
        step();
        drive(2'b11, 32'hFFFF_FFFF, 32'd6, 1'b1, 1'b0);
        step();
        chk_out("acc1", 1'b1, 64'd6, 1'b0);
        idle();
        step();
        chk_out("acc2", 1'b1, 64'd26, 1'b0);
        step();
        chk_out("acc3", 1'b1, 64'd20, 1'b0);
        step();
        chk_out("acc_hold", 1'b0, 64'd20, 1'b0);

        // Overflow, stickiness, plain multiply clears, clear beat restarts.
        drive(2'b11, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        step();
        drive(2'b11, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        step();
        drive(2'b11, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        chk_out("ovf1", 1'b1, 64'h4000_0000_0000_0000, 1'b0);
        drive(2'b11, 32'd1, 32'd2, 1'b0, 1'b0);
        step();
        chk_out("ovf2", 1'b1, 64'h8000_0000_0000_0000, 1'b1);
        drive(2'b11, 32'd1, 32'd1, 1'b1, 1'b1);
        step();
        chk_out("ovf_sticky", 1'b1, 64'h8000_0000_0000_0000, 1'b1);
        idle();
        step();
        chk_out("ovf_plain", 1'b1, 64'd2, 1'b0);
        step();
        chk_out("ovf_clr", 1'b1, 64'd1, 1'b0);
        step();
        step();

        // ce freeze with beats in flight; a beat offered while ce=0 must be ignored.
        drive(2'b11, 32'd5, 32'd6, 1'b0, 1'b0);
        step();
        drive(2'b11, 32'd7, 32'd8, 1'b0, 1'b0);
        step();
        drive(2'b11, 32'd9, 32'd11, 1'b0, 1'b0);
        step();
        chk_out("ce_pre", 1'b1, 64'd30, 1'b0);
        ce = 1'b0;
        drive(2'b11, 32'd100, 32'd100, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out($sformatf("ce_frz%0d", i), 1'b1, 64'd30, 1'b0);
        end
        ce = 1'b1;
        idle();
        step();
        chk_out("ce_out2", 1'b1, 64'd56, 1'b0);
        step();
        chk_out("ce_out3", 1'b1, 64'd99, 1'b0);
        step();
        chk_out("ce_after", 1'b0, 64'd99, 1'b0);

        // Asynchronous reset with two beats in flight.
        drive(2'b00, 32'd5, 32'd17, 1'b0, 1'b0);
        step();
        idle();
        step();
        step();
        chk_out("rst_pre", 1'b1, 64'h55, 1'b0);
        drive(2'b00, 32'd2, 32'd2, 1'b0, 1'b0);
        step();
        drive(2'b00, 32'd3, 32'd3, 1'b0, 1'b0);
        step();
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk_out("rst_async", 1'b0, 64'd0, 1'b0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("rst_quiet%0d", i), 1'b0, 64'd0, 1'b0);
        end
        drive(2'b00, 32'd4, 32'd4, 1'b0, 1'b0);
        step();
        idle();
        step();
        check("rst_new_early", {63'd0, out_valid}, 64'd0);
        step();
        chk_out("rst_new", 1'b1, 64'd16, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
